// File: rtl/coco_mmu_dat.sv
// CoCo MMU with internal DAT file: translates CPU addresses to 8 KB physical pages,
// with an indirect DAT edit window, delayed task switch and supervisor entry on vector fetch.
module coco_mmu_dat #(
  parameter int unsigned TASK_BITS    = 2,
  parameter int unsigned PHYS_BITS    = 8,
  parameter int unsigned SWITCH_DELAY = 2
) (
  input  logic                 e,
  input  logic                 _reset,
  input  logic                 ba,
  input  logic                 bs,
  input  logic                 r_w_cpu,
  input  logic [15:0]          address_cpu,
  inout  wire  [7:0]           data_cpu,
  output logic [PHYS_BITS-1:0] phys_page,
  output logic                 mem_internal,
  output logic                 reg_hit,
  output logic [TASK_BITS-1:0] active_task
);

  localparam int unsigned NTASK  = 1 << TASK_BITS;
  localparam int unsigned ONES_W = PHYS_BITS - 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [ONES_W-1:0] ONES = '1;

  typedef enum logic {S_IDLE, S_PEND} sw_state_t;

  // Programmer-visible registers
  logic                 mmu_en, crm_en, auto_sup;
  logic [TASK_BITS-1:0] request, edit;
  logic [PHYS_BITS-1:0] dat [NTASK][8];

  // Task-switch state
  sw_state_t            state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TASK_BITS-1:0] active_q, active_d, saved_q, saved_d;
  logic                 sup_q, sup_d;

  logic       is_ff, is_fe, sel_ctl, sel_dat, wr, task_wr, vec_fetch;
  logic [7:0] rd_data, status;

  assign is_ff     = address_cpu[15:8] == 8'hFF;
  assign is_fe     = address_cpu[15:8] == 8'hFE;
  assign sel_ctl   = address_cpu[15:2] == 14'h3FE4;
  assign sel_dat   = address_cpu[15:3] == 13'h1FF4;
  assign reg_hit   = sel_ctl | sel_dat;
  assign wr        = !r_w_cpu & reg_hit;
  assign task_wr   = wr & sel_ctl & (address_cpu[1:0] == 2'd1);
  assign vec_fetch = mmu_en & auto_sup & !ba & bs;

  assign active_task = active_q;

  // Control register writes
  always_ff @(negedge e or negedge _reset) begin
    if (!_reset) begin
      mmu_en   <= 1'b0;
      crm_en   <= 1'b0;
      auto_sup <= 1'b0;
      request  <= '0;
      edit     <= '0;
    end else if (wr && sel_ctl) begin
      case (address_cpu[1:0])
        2'd0: begin
          mmu_en   <= data_cpu[6];
          crm_en   <= data_cpu[3];
          auto_sup <= data_cpu[0];
        end
        2'd1:    request <= data_cpu[TASK_BITS-1:0];
        2'd2:    edit    <= data_cpu[TASK_BITS-1:0];
        default: ;
      endcase
    end
  end

  // DAT file; reset maps every bank to the motherboard identity page
  always_ff @(negedge e or negedge _reset) begin
    if (!_reset) begin
      for (int t = 0; t < NTASK; t++) begin
        for (int b = 0; b < 8; b++) begin
          dat[t][b] <= {ONES, 3'(b)};
        end
      end
    end else if (wr && sel_dat) begin
      dat[edit][address_cpu[2:0]] <= data_cpu[PHYS_BITS-1:0];
    end
  end

  always_ff @(negedge e or negedge _reset) begin
    if (!_reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      active_q <= '0;
      saved_q  <= '0;
      sup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      active_q <= active_d;
      saved_q  <= saved_d;
      sup_q    <= sup_d;
    end
  end

  // Vector fetch beats a task write; a task write restarts the delay
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    active_d = active_q;
    saved_d  = saved_q;
    sup_d    = sup_q;
    if (vec_fetch) begin
      state_d  = S_IDLE;
      count_d  = '0;
      active_d = '0;
      if (!sup_q) begin
        sup_d   = 1'b1;
        saved_d = active_q;
      end
    end else if (task_wr) begin
      state_d = S_PEND;
      count_d = CNT_W'(SWITCH_DELAY);
    end else begin
      case (state_q)
        S_PEND: begin
          if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            active_d = request;
            sup_d    = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status                  = '0;
    status[7]               = state_q == S_PEND;
    status[6]               = sup_q;
    status[TASK_BITS-1:0]   = saved_q;
  end

  always_comb begin
    rd_data = '0;
    if (sel_ctl) begin
      case (address_cpu[1:0])
        2'd0:    rd_data = {1'b0, mmu_en, 2'b00, crm_en, 2'b00, auto_sup};
        2'd1:    rd_data = 8'(request);
        2'd2:    rd_data = 8'(edit);
        default: rd_data = status;
      endcase
    end else if (sel_dat) begin
      rd_data = 8'(dat[edit][address_cpu[2:0]]);
    end
  end

  assign data_cpu = (e & r_w_cpu & reg_hit) ? rd_data : 8'bz;

  // I/O page (and FExx with crm_en) always lands on the motherboard top page
  always_comb begin
    if (!mmu_en) begin
      phys_page = {ONES, address_cpu[15:13]};
    end else if (is_ff || (crm_en && is_fe)) begin
      phys_page = {ONES, 3'b111};
    end else begin
      phys_page = dat[active_q][address_cpu[15:13]];
    end
  end

  // Top-page accesses that fall into the FFxx window are mirrored internally
  assign mem_internal = (phys_page[PHYS_BITS-1:3] != ONES) |
                        ((phys_page[2:0] == 3'b111) & (address_cpu[12:8] == 5'h1F) & !is_ff);

endmodule

// File: tb/tb_coco_mmu_dat.sv
// Directed vector bench for coco_mmu_dat (TASK_BITS=2, PHYS_BITS=8, SWITCH_DELAY=2).
module tb_coco_mmu_dat;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wd;
    logic        vf;
    logic        chk_d;
    logic [7:0]  exp_d;
    logic [7:0]  exp_pg;
    logic        exp_mi;
    logic        exp_hit;
    logic [1:0]  exp_at;
  } vec_t;

  logic        e = 1'b0;
  logic        _reset;
  logic        ba, bs, r_w_cpu;
  logic [15:0] address_cpu;
  logic [7:0]  data_drv;
  logic        data_oe;
  wire  [7:0]  data_cpu;
  logic [7:0]  phys_page;
  logic        mem_internal, reg_hit;
  logic [1:0]  active_task;

  int applied = 0;
  int miscompares = 0;
  vec_t vecs[$];

  logic [7:0] s_d, s_pg;
  logic       s_mi, s_hit;
  logic [1:0] s_at;

  assign data_cpu = data_oe ? data_drv : 8'bz;

  coco_mmu_dat #(.TASK_BITS(2), .PHYS_BITS(8), .SWITCH_DELAY(2)) dut (
    .e(e), ._reset(_reset), .ba(ba), .bs(bs), .r_w_cpu(r_w_cpu),
    .address_cpu(address_cpu), .data_cpu(data_cpu), .phys_page(phys_page),
    .mem_internal(mem_internal), .reg_hit(reg_hit), .active_task(active_task)
  );

  always #5 e = ~e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic vf,
                     input logic chk, input logic [7:0] ed, input logic [7:0] pg,
                     input logic mi, input logic hit, input logic [1:0] at);
    vec_t v;
    v.addr = a; v.rw = rw; v.wd = wd; v.vf = vf; v.chk_d = chk; v.exp_d = ed;
    v.exp_pg = pg; v.exp_mi = mi; v.exp_hit = hit; v.exp_at = at;
    vecs.push_back(v);
  endtask

  // Called just after a falling edge: drive, sample in the high phase, then let the edge happen
  task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic vf);
    address_cpu = a; r_w_cpu = rw; data_drv = wd; data_oe = !rw; ba = !vf; bs = vf;
    @(posedge e); #1;
    s_d = data_cpu; s_pg = phys_page; s_mi = mem_internal; s_hit = reg_hit; s_at = active_task;
    @(negedge e); #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      cyc(v.addr, v.rw, v.wd, v.vf);
      applied++;
      if ((v.chk_d && s_d !== v.exp_d) || s_pg !== v.exp_pg || s_mi !== v.exp_mi ||
          s_hit !== v.exp_hit || s_at !== v.exp_at) begin
        miscompares++;
        $display("FAIL %s[%0d] addr=%h: got d=%h pg=%h mi=%b hit=%b at=%0d; want d=%h pg=%h mi=%b hit=%b at=%0d",
                 tag, i, v.addr, s_d, s_pg, s_mi, s_hit, s_at,
                 v.exp_d, v.exp_pg, v.exp_mi, v.exp_hit, v.exp_at);
      end
    end
    vecs.delete();
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    _reset = 1'b0; ba = 1'b1; bs = 1'b0; r_w_cpu = 1'b1;
    address_cpu = 16'h0000; data_drv = 8'h00; data_oe = 1'b0;
    repeat (2) @(negedge e);
    #1 _reset = 1'b1;

    //   addr      rw wd    vf chk d      page   mi hit at
    add(16'hFF90, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF91, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'hFB, 0, 0, 0);
    add(16'h1F40, 1, 8'h00, 0, 0, 8'h00, 8'hF8, 0, 0, 0);
    add(16'hFF92, 0, 8'h01, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFFA3, 0, 8'h12, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF90, 0, 8'h40, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'hFB, 0, 0, 0);
    add(16'hFFA3, 1, 8'h00, 0, 1, 8'h12, 8'hFF, 0, 1, 0);
    // task switch to 1 with two-cycle delay
    add(16'hFF91, 0, 8'h01, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h80, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h80, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h80, 8'hFF, 0, 1, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'h12, 1, 0, 1);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 1);
    add(16'hFF91, 1, 8'h00, 0, 1, 8'h01, 8'hFF, 0, 1, 1);
    // supervisor entry on a two-byte vector fetch
    add(16'hFF90, 0, 8'h41, 0, 0, 8'h00, 8'hFF, 0, 1, 1);
    add(16'hFFFE, 1, 8'h00, 1, 0, 8'h00, 8'hFF, 0, 0, 1);
    add(16'hFFFF, 1, 8'h00, 1, 0, 8'h00, 8'hFF, 0, 0, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h41, 8'hFF, 0, 1, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'hFB, 0, 0, 0);
    // task write colliding with vector fetch
    add(16'hFF91, 0, 8'h02, 1, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h41, 8'hFF, 0, 1, 0);
    add(16'hFF91, 1, 8'h00, 0, 1, 8'h02, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h41, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'h41, 8'hFF, 0, 1, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'hFB, 0, 0, 0);
    // constant RAM window, I/O page and top-page mirror
    add(16'hFF90, 0, 8'h48, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF92, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFFA7, 0, 8'h05, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFE10, 1, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0, 0);
    add(16'hFF22, 1, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0, 0);
    add(16'hE000, 1, 8'h00, 0, 0, 8'h00, 8'h05, 1, 0, 0);
    add(16'hFFA0, 0, 8'hFF, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'h1F40, 1, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0, 0);
    add(16'hFFA0, 1, 8'h00, 0, 1, 8'hFF, 8'hFF, 0, 1, 0);
    add(16'hFF90, 1, 8'h00, 0, 1, 8'h48, 8'hFF, 0, 1, 0);
    run_table("main");

    // reset while a switch is pending (count=1, sup still set)
    add(16'hFF91, 0, 8'h03, 0, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF93, 1, 8'h00, 0, 1, 8'hC1, 8'hFF, 0, 1, 0);
    run_table("pend");
    address_cpu = 16'hE000; r_w_cpu = 1'b1; data_oe = 1'b0;
    _reset = 1'b0;
    #1;
    chk("async_reset_active_task", 8'(active_task), 8'h00);
    chk("async_reset_phys_page", phys_page, 8'hFF);
    repeat (2) @(negedge e);
    #1 _reset = 1'b1;

    add(16'hFF93, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF90, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFF91, 1, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(16'hFFA0, 1, 8'h00, 0, 1, 8'hF8, 8'hFF, 0, 1, 0);
    add(16'hFFA7, 1, 8'h00, 0, 1, 8'hFF, 8'hFF, 0, 1, 0);
    add(16'hE000, 1, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'hFB, 0, 0, 0);
    add(16'h6000, 1, 8'h00, 0, 0, 8'h00, 8'hFB, 0, 0, 0);
    run_table("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
